// File: rtl/uart_port_bridge_if.sv
// Signal bundle between the UART FIFOs / port bus and uart_port_bridge.
// master = bridge side, slave = FIFO/port-bus environment side.
interface uart_port_bridge_if;
  logic [7:0] rx_data;
  logic       rx_data_present;
  logic       rx_read;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       tx_write;
  logic [7:0] port_id;
  logic [7:0] port_out;
  logic [7:0] port_in;
  logic       write_strobe;
  logic       read_strobe;
  logic       busy;
  logic       frame_err;

  modport master (
    input  rx_data, rx_data_present, tx_full, port_in,
    output rx_read, tx_data, tx_write, port_id, port_out,
           write_strobe, read_strobe, busy, frame_err
  );

  modport slave (
    output rx_data, rx_data_present, tx_full, port_in,
    input  rx_read, tx_data, tx_write, port_id, port_out,
           write_strobe, read_strobe, busy, frame_err
  );
endinterface

// File: rtl/uart_port_bridge.sv
// UART byte-frame to port-bus bridge: 'W' addr data writes, 'R' addr reads and replies.
// Define UART_PORT_BRIDGE_WRITE_ACK_EN to answer every write with an 0x06 byte.
module uart_port_bridge #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic             clk,
  input logic             reset,
  uart_port_bridge_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_WR_STROBE,
    ST_RD_SETUP,
    ST_RD_STROBE,
    ST_TX_WAIT
  } state_t;

  localparam logic [7:0]  OP_WRITE = 8'h57;
  localparam logic [7:0]  OP_READ  = 8'h52;
  localparam logic [7:0]  BYTE_NAK = 8'h15;
  localparam logic [7:0]  BYTE_ACK = 8'h06;
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        is_write;
  logic [7:0]  addr;
  logic [31:0] to_cnt;
  logic        take;
  logic        timed_out;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // The FIFO head is stale while rx_read is high, so never take a byte then.
  assign take = bus.rx_data_present && !bus.rx_read &&
                (state == ST_IDLE || state == ST_GET_ADDR || state == ST_GET_DATA);
  assign timed_out = (to_cnt >= TO_LAST);
  assign bus.busy  = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (take && state == ST_GET_ADDR) addr <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      is_write         <= 1'b0;
      to_cnt           <= 32'd0;
      bus.rx_read      <= 1'b0;
      bus.tx_write     <= 1'b0;
      bus.write_strobe <= 1'b0;
      bus.read_strobe  <= 1'b0;
      bus.frame_err    <= 1'b0;
      bus.port_id      <= 8'h00;
      bus.port_out     <= 8'h00;
      bus.tx_data      <= 8'h00;
    end else begin
      bus.rx_read      <= 1'b0;
      bus.tx_write     <= 1'b0;
      bus.write_strobe <= 1'b0;
      bus.read_strobe  <= 1'b0;
      bus.frame_err    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (take) begin
            bus.rx_read <= 1'b1;
            if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
              is_write <= (bus.rx_data == OP_WRITE);
              to_cnt   <= 32'd0;
              state    <= ST_GET_ADDR;
            end else begin
              bus.frame_err <= 1'b1;
              bus.tx_data   <= BYTE_NAK;
              state         <= ST_TX_WAIT;
            end
          end
        end

        ST_GET_ADDR: begin
          if (take) begin
            bus.rx_read <= 1'b1;
            to_cnt      <= 32'd0;
            if (is_write) begin
              state <= ST_GET_DATA;
            end else begin
              bus.port_id <= bus.rx_data;
              state       <= ST_RD_SETUP;
            end
          end else if (timed_out) begin
            bus.frame_err <= 1'b1;
            to_cnt        <= 32'd0;
            state         <= ST_IDLE;
          end else begin
            to_cnt <= sat_inc(to_cnt);
          end
        end

        ST_GET_DATA: begin
          if (take) begin
            bus.rx_read      <= 1'b1;
            to_cnt           <= 32'd0;
            bus.port_id      <= addr;
            bus.port_out     <= bus.rx_data;
            bus.write_strobe <= 1'b1;
            state            <= ST_WR_STROBE;
          end else if (timed_out) begin
            bus.frame_err <= 1'b1;
            to_cnt        <= 32'd0;
            state         <= ST_IDLE;
          end else begin
            to_cnt <= sat_inc(to_cnt);
          end
        end

        ST_WR_STROBE: begin
`ifdef UART_PORT_BRIDGE_WRITE_ACK_EN
          bus.tx_data <= BYTE_ACK;
          state       <= ST_TX_WAIT;
`else
          state       <= ST_IDLE;
`endif
        end

        // Responder registers port_in one cycle after port_id settles.
        ST_RD_SETUP: begin
          bus.read_strobe <= 1'b1;
          state           <= ST_RD_STROBE;
        end

        ST_RD_STROBE: begin
          bus.tx_data <= bus.port_in;
          state       <= ST_TX_WAIT;
        end

        ST_TX_WAIT: begin
          if (!bus.tx_full) begin
            bus.tx_write <= 1'b1;
            state        <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_port_bridge.sv
// Scoreboard bench for uart_port_bridge: directed frames, queued expectations, negedge monitor.
module tb_uart_port_bridge;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_port_bridge_if bus();

  uart_port_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tx_count = 0;
  int exp_err = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] resp(input logic [7:0] id);
    case (id)
      8'h08:   return 8'h3C;
      8'h01:   return 8'h5A;
      default: return ~id;
    endcase
  endfunction

  // Receive FIFO model: first-word-fall-through head, popped by rx_read.
  initial begin
    bus.rx_data = 8'h00;
    bus.rx_data_present = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rx_read && rx_q.size() > 0) void'(rx_q.pop_front());
      bus.rx_data_present = (rx_q.size() > 0);
      bus.rx_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  // Port responder with one cycle of registered latency.
  initial begin
    bus.port_in = 8'h00;
    forever begin
      @(posedge clk);
      bus.port_in <= resp(bus.port_id);
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe, push or error.
  initial begin
    logic [15:0] w;
    logic [7:0]  r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.write_strobe) begin
          check("strobe_exclusive", {31'b0, bus.read_strobe}, 32'd0);
          check("wr_expected", {31'b0, exp_wr.size() != 0}, 32'd1);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            check("wr_port_id", {24'b0, bus.port_id}, {24'b0, w[15:8]});
            check("wr_port_out", {24'b0, bus.port_out}, {24'b0, w[7:0]});
          end
        end
        if (bus.read_strobe) begin
          check("rd_expected", {31'b0, exp_rd.size() != 0}, 32'd1);
          if (exp_rd.size() != 0) begin
            r = exp_rd.pop_front();
            check("rd_port_id", {24'b0, bus.port_id}, {24'b0, r});
          end
        end
        if (bus.tx_write) begin
          tx_count++;
          check("tx_while_full", {31'b0, bus.tx_full}, 32'd0);
          check("tx_expected", {31'b0, exp_tx.size() != 0}, 32'd1);
          if (exp_tx.size() != 0) begin
            r = exp_tx.pop_front();
            check("tx_data", {24'b0, bus.tx_data}, {24'b0, r});
          end
        end
        if (bus.frame_err) begin
          check("err_expected", {31'b0, exp_err > 0}, 32'd1);
          if (exp_err > 0) exp_err--;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_read"},      {31'b0, bus.rx_read},      32'd0);
    check({tag, "_tx_write"},     {31'b0, bus.tx_write},     32'd0);
    check({tag, "_write_strobe"}, {31'b0, bus.write_strobe}, 32'd0);
    check({tag, "_read_strobe"},  {31'b0, bus.read_strobe},  32'd0);
    check({tag, "_frame_err"},    {31'b0, bus.frame_err},    32'd0);
    check({tag, "_busy"},         {31'b0, bus.busy},         32'd0);
    check({tag, "_port_id"},      {24'b0, bus.port_id},      32'd0);
    check({tag, "_port_out"},     {24'b0, bus.port_out},     32'd0);
    check({tag, "_tx_data"},      {24'b0, bus.tx_data},      32'd0);
  endtask

  task automatic wait_done(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (rx_q.size() == 0 && !bus.busy && !bus.rx_read && !bus.tx_write &&
          !bus.frame_err && exp_tx.size() == 0 && exp_wr.size() == 0 &&
          exp_rd.size() == 0 && exp_err == 0)
        done = 1'b1;
    end
    check({name, "_done"}, {31'b0, done}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int snap;
    bus.tx_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Write frame
    exp_wr.push_back(16'h0AA5);
`ifdef UART_PORT_BRIDGE_WRITE_ACK_EN
    exp_tx.push_back(8'h06);
`endif
    push_byte(8'h57); push_byte(8'h0A); push_byte(8'hA5);
    wait_done("write", 200);
    check("hold_port_id", {24'b0, bus.port_id}, 32'h0A);
    check("hold_port_out", {24'b0, bus.port_out}, 32'hA5);

    // Read frame
    exp_rd.push_back(8'h08);
    exp_tx.push_back(8'h3C);
    push_byte(8'h52); push_byte(8'h08);
    wait_done("read", 200);
    check("read_hold_port_out", {24'b0, bus.port_out}, 32'hA5);

    // Bad opcode
    exp_err++;
    exp_tx.push_back(8'h15);
    push_byte(8'h41);
    wait_done("bad_op", 200);

    // Timeout after lone opcode, then a normal read
    exp_err++;
    push_byte(8'h57);
    wait_done("timeout", 4 * TO);
    check("timeout_busy", {31'b0, bus.busy}, 32'd0);
    exp_rd.push_back(8'h01);
    exp_tx.push_back(8'h5A);
    push_byte(8'h52); push_byte(8'h01);
    wait_done("post_timeout_read", 200);

    // Read reply held off by tx_full
    bus.tx_full = 1'b1;
    snap = tx_count;
    exp_rd.push_back(8'h08);
    exp_tx.push_back(8'h3C);
    push_byte(8'h52); push_byte(8'h08);
    repeat (20) @(posedge clk);
    #1;
    check("full_no_push", tx_count, snap);
    check("full_busy", {31'b0, bus.busy}, 32'd1);
    check("full_pending", exp_tx.size(), 32'd1);
    bus.tx_full = 1'b0;
    wait_done("full_release", 200);
    check("full_one_push", tx_count, snap + 1);

    // Reset in the middle of a write frame
    push_byte(8'h57); push_byte(8'h0A);
    repeat (6) @(posedge clk);
    #1;
    check("mid_busy", {31'b0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    reset = 1'b0;
    exp_wr.push_back(16'h2233);
`ifdef UART_PORT_BRIDGE_WRITE_ACK_EN
    exp_tx.push_back(8'h06);
`endif
    push_byte(8'h57); push_byte(8'h22); push_byte(8'h33);
    wait_done("post_reset_write", 200);
    check("post_reset_port_id", {24'b0, bus.port_id}, 32'h22);

    check("final_rx_empty", rx_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
